// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage and IF/ID pipeline register.
// Keeps the PC, runs the rd_en/ack handshake towards instruction memory,
// parks a response in a one-entry buffer while IF is stalled, and drains a
// request whose response became stale because of a redirect.
module fetch_unit #(
  parameter int                   DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall_if,
  input  logic                 stall_id,
  input  logic                 flush_id,
  input  logic [1:0]           pc_src,
  input  logic [DATA_SIZE-1:0] new_pc,
  output logic                 inst_mem_rd_en,
  output logic [DATA_SIZE-1:0] inst_mem_addr,
  input  logic                 inst_mem_ack,
  input  logic [31:0]          inst_mem_rd_dat,
  output logic [DATA_SIZE-1:0] pc_id,
  output logic [DATA_SIZE-1:0] pc_plus_4_id,
  output logic [31:0]          inst_id,
  output logic                 valid_id
);

  // pc_src encoding: 0 selects sequential PC+4, anything else is a redirect
  localparam logic [1:0] PC_PLUS_4 = 2'd0;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [DATA_SIZE-1:0] ADDR_MASK = ~DATA_SIZE'(3);
  localparam logic [DATA_SIZE-1:0] FOUR      = DATA_SIZE'(4);
  localparam logic [31:0]          NOP       = 32'h0000_0013;

  logic [1:0]           state_q, state_d;
  logic [DATA_SIZE-1:0] pc_q, pc_d;
  logic [DATA_SIZE-1:0] drain_addr_q, drain_addr_d;
  logic [DATA_SIZE-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]          hold_dat_q, hold_dat_d;

  logic [DATA_SIZE-1:0] pc_id_q, pc_id_d;
  logic [DATA_SIZE-1:0] pc_plus_4_id_q, pc_plus_4_id_d;
  logic [31:0]          inst_id_q, inst_id_d;
  logic                 valid_id_q, valid_id_d;

  logic                 redirect;
  logic                 avail;
  logic [DATA_SIZE-1:0] avail_pc;
  logic [31:0]          avail_dat;
  logic [DATA_SIZE-1:0] target_pc;

  assign redirect  = (pc_src != PC_PLUS_4);
  assign target_pc = new_pc & ADDR_MASK;

  // Request is live in FETCH and DRAIN; DRAIN keeps presenting the abandoned address
  assign inst_mem_rd_en = reset && (state_q != HOLD);
  assign inst_mem_addr  = ((state_q == DRAIN) ? drain_addr_q : pc_q) & ADDR_MASK;

  assign pc_id        = pc_id_q;
  assign pc_plus_4_id = pc_plus_4_id_q;
  assign inst_id      = inst_id_q;
  assign valid_id     = valid_id_q;

  // Fetch FSM: next PC, hold buffer, drain address and the instruction offered to IF/ID
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_dat_d   = hold_dat_q;
    avail        = 1'b0;
    avail_pc     = pc_q;
    avail_dat    = inst_mem_rd_dat;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = target_pc;
          if (!inst_mem_ack) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (inst_mem_ack) begin
          pc_d = pc_q + FOUR;
          if (stall_if) begin
            hold_pc_d  = pc_q;
            hold_dat_d = inst_mem_rd_dat;
            state_d    = HOLD;
          end else begin
            avail = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target_pc;
          state_d = FETCH;
        end else if (!stall_if) begin
          avail     = 1'b1;
          avail_pc  = hold_pc_q;
          avail_dat = hold_dat_q;
          state_d   = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d = target_pc;
        end
        if (inst_mem_ack) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // IF/ID register: flush beats stall, stall beats a new instruction, idle loads a bubble
  always_comb begin
    pc_id_d        = pc_id_q;
    pc_plus_4_id_d = pc_plus_4_id_q;
    inst_id_d      = inst_id_q;
    valid_id_d     = valid_id_q;
    if (flush_id) begin
      inst_id_d  = NOP;
      valid_id_d = 1'b0;
    end else if (stall_id) begin
      valid_id_d = valid_id_q;
    end else if (avail) begin
      pc_id_d        = avail_pc;
      pc_plus_4_id_d = avail_pc + FOUR;
      inst_id_d      = avail_dat;
      valid_id_d     = 1'b1;
    end else begin
      inst_id_d  = NOP;
      valid_id_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC & ADDR_MASK;
      drain_addr_q   <= '0;
      hold_pc_q      <= '0;
      hold_dat_q     <= '0;
      pc_id_q        <= '0;
      pc_plus_4_id_q <= FOUR;
      inst_id_q      <= NOP;
      valid_id_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      drain_addr_q   <= drain_addr_d;
      hold_pc_q      <= hold_pc_d;
      hold_dat_q     <= hold_dat_d;
      pc_id_q        <= pc_id_d;
      pc_plus_4_id_q <= pc_plus_4_id_d;
      inst_id_q      <= inst_id_d;
      valid_id_q     <= valid_id_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a transaction-level fetch model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        stall_if, stall_id, flush_id;
  logic [1:0]  pc_src;
  logic [31:0] new_pc;
  logic        inst_mem_rd_en;
  logic [31:0] inst_mem_addr;
  logic        inst_mem_ack;
  logic [31:0] inst_mem_rd_dat;
  logic [31:0] pc_id, pc_plus_4_id, inst_id;
  logic        valid_id;

  logic        use_rand;
  logic [31:0] rand_dat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: what the fetch stage is doing, in transaction terms
  logic [31:0] m_pc;          // next instruction address to fetch
  logic        m_stale;       // an abandoned request is still waiting for its ack
  logic [31:0] m_stale_addr;
  logic        m_held;        // a fetched instruction is parked while IF stalls
  logic [31:0] m_held_pc, m_held_dat;
  logic [31:0] e_pc_id, e_pc4, e_inst;
  logic        e_valid;

  fetch_unit #(.DATA_SIZE(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .pc_src(pc_src), .new_pc(new_pc),
    .inst_mem_rd_en(inst_mem_rd_en), .inst_mem_addr(inst_mem_addr),
    .inst_mem_ack(inst_mem_ack), .inst_mem_rd_dat(inst_mem_rd_dat),
    .pc_id(pc_id), .pc_plus_4_id(pc_plus_4_id), .inst_id(inst_id), .valid_id(valid_id)
  );

  // Memory returns an address-tagged word in directed mode, random words otherwise
  assign inst_mem_rd_dat = use_rand ? rand_dat : (inst_mem_addr ^ 32'h1000_0000);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic exp_rd_en();
    return reset && !m_held;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees
  task automatic model_update();
    logic        live;
    logic        deliver;
    logic [31:0] dpc, ddat;
    logic        redir;
    if (!reset) begin
      m_pc = 32'h0; m_stale = 1'b0; m_stale_addr = 32'h0;
      m_held = 1'b0; m_held_pc = 32'h0; m_held_dat = 32'h0;
      e_pc_id = 32'h0; e_pc4 = 32'h4; e_inst = NOP; e_valid = 1'b0;
      return;
    end
    live    = exp_rd_en();
    redir   = (pc_src != 2'd0);
    deliver = 1'b0;
    dpc     = 32'h0;
    ddat    = 32'h0;
    if (m_held) begin
      if (redir) begin
        m_held = 1'b0;
        m_pc   = new_pc & ~32'h3;
      end else if (!stall_if) begin
        deliver = 1'b1; dpc = m_held_pc; ddat = m_held_dat;
        m_held  = 1'b0;
      end
    end else if (m_stale) begin
      if (inst_mem_ack && live) m_stale = 1'b0;
      if (redir) m_pc = new_pc & ~32'h3;
    end else begin
      if (redir) begin
        if (!inst_mem_ack) begin
          m_stale = 1'b1; m_stale_addr = m_pc;
        end
        m_pc = new_pc & ~32'h3;
      end else if (inst_mem_ack) begin
        if (stall_if) begin
          m_held = 1'b1; m_held_pc = m_pc; m_held_dat = inst_mem_rd_dat;
        end else begin
          deliver = 1'b1; dpc = m_pc; ddat = inst_mem_rd_dat;
        end
        m_pc = m_pc + 32'd4;
      end
    end
    if (flush_id) begin
      e_inst = NOP; e_valid = 1'b0;
    end else if (stall_id) begin
      e_valid = e_valid;
    end else if (deliver) begin
      e_pc_id = dpc; e_pc4 = dpc + 32'd4; e_inst = ddat; e_valid = 1'b1;
    end else begin
      e_inst = NOP; e_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("rd_en", {31'b0, inst_mem_rd_en}, {31'b0, exp_rd_en()});
    if (exp_rd_en()) chk("addr", inst_mem_addr, exp_addr());
    chk("valid_id", {31'b0, valid_id}, {31'b0, e_valid});
    chk("inst_id", inst_id, e_inst);
    chk("pc_id", pc_id, e_pc_id);
    chk("pc_plus_4_id", pc_plus_4_id, e_pc4);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
    #1;
    cyc++;
    check_all();
    $display("cyc %0d rst %b ack %b rd_en %b addr %h valid %b pc_id %h inst %h",
             cyc, reset, inst_mem_ack, inst_mem_rd_en, inst_mem_addr, valid_id, pc_id, inst_id);
  endtask

  initial begin
    reset = 1'b0; stall_if = 1'b0; stall_id = 1'b0; flush_id = 1'b0;
    pc_src = 2'd0; new_pc = 32'h0; inst_mem_ack = 1'b0;
    use_rand = 1'b0; rand_dat = 32'h0;

    // Reset values
    cycle(); cycle();
    chk("lit_rst_rd_en", {31'b0, inst_mem_rd_en}, 32'h0);
    chk("lit_rst_inst", inst_id, 32'h13);
    chk("lit_rst_pc4", pc_plus_4_id, 32'h4);

    // Immediate ack streams one instruction per cycle
    reset = 1'b1; inst_mem_ack = 1'b1;
    cycle();
    chk("lit_seq_addr", inst_mem_addr, 32'h4);
    chk("lit_seq_pc", pc_id, 32'h0);
    chk("lit_seq_inst", inst_id, 32'h1000_0000);
    chk("lit_seq_valid", {31'b0, valid_id}, 32'h1);
    cycle();
    chk("lit_seq_inst2", inst_id, 32'h1000_0004);
    chk("lit_seq_pc4", pc_plus_4_id, 32'h8);

    // Redirect with ack discards data; PC wraps past the top of memory
    pc_src = 2'd1; new_pc = 32'hFFFF_FFFC;
    cycle();
    pc_src = 2'd0;
    chk("lit_redir_addr", inst_mem_addr, 32'hFFFF_FFFC);
    chk("lit_redir_valid", {31'b0, valid_id}, 32'h0);
    cycle();
    chk("lit_wrap_addr", inst_mem_addr, 32'h0);
    chk("lit_wrap_pc", pc_id, 32'hFFFF_FFFC);
    chk("lit_wrap_pc4", pc_plus_4_id, 32'h0);
    chk("lit_wrap_inst", inst_id, 32'hEFFF_FFFC);

    // Flush wins over stall_id
    flush_id = 1'b1; stall_id = 1'b1;
    cycle();
    flush_id = 1'b0; stall_id = 1'b0;
    chk("lit_flush_valid", {31'b0, valid_id}, 32'h0);
    chk("lit_flush_inst", inst_id, NOP);

    // Stall IF on ack parks the word; redirect in HOLD drops it
    stall_if = 1'b1;
    cycle();
    chk("lit_hold_rd_en", {31'b0, inst_mem_rd_en}, 32'h0);
    pc_src = 2'd1; new_pc = 32'h0000_0103;
    cycle();
    pc_src = 2'd0; stall_if = 1'b0;
    chk("lit_hold_redir_rd_en", {31'b0, inst_mem_rd_en}, 32'h1);
    chk("lit_hold_redir_addr", inst_mem_addr, 32'h100);

    // Redirect while a request is pending: old address held until its ack
    inst_mem_ack = 1'b0;
    cycle();
    pc_src = 2'd1; new_pc = 32'h200;
    cycle();
    pc_src = 2'd0;
    chk("lit_drain_addr", inst_mem_addr, 32'h100);
    cycle();
    chk("lit_drain_addr2", inst_mem_addr, 32'h100);
    inst_mem_ack = 1'b1;
    cycle();
    chk("lit_drain_next", inst_mem_addr, 32'h200);
    chk("lit_drain_drop", {31'b0, valid_id}, 32'h0);
    cycle();
    chk("lit_drain_pc", pc_id, 32'h200);

    // Reset while a request is outstanding
    inst_mem_ack = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    chk("lit_midrst_rd_en", {31'b0, inst_mem_rd_en}, 32'h0);
    chk("lit_midrst_valid", {31'b0, valid_id}, 32'h0);
    reset = 1'b1;

    // Randomized traffic against the model
    use_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 99) != 0);
      inst_mem_ack = ($urandom_range(0, 2) != 0);
      stall_if     = ($urandom_range(0, 4) == 0);
      stall_id     = ($urandom_range(0, 9) == 0);
      flush_id     = ($urandom_range(0, 19) == 0);
      pc_src       = ($urandom_range(0, 14) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      new_pc       = $urandom;
      rand_dat     = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
